div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 110 +++++++++++
 tb/tb_div_seq.sv | 104 ++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: 32-bit sequential restoring divider, {remainder, quotient} after 32 steps.
// Optional DIV_ANNUL_EN: annul_i aborts an operation in flight.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;
  state_t      state, state_nx;
  logic [5:0]  cnt, cnt_nx;
  logic [64:0] w, w_nx, sh, step;
  logic [32:0] diff;
  logic [31:0] dvs, dvs_nx, mag1, mag2, q, r, fix_q, fix_r;
  logic        sgn, sgn_nx, s1, s1_nx, s2, s2_nx;
  logic [63:0] result_nx;
  logic        ready_nx, annul_x, latch;
`ifdef DIV_ANNUL_EN
  assign annul_x = annul_i;
`else
  assign annul_x = 1'b0;
`endif
  assign latch  = start_i && !annul_i;
  assign busy_o = (state == DIVZERO) || (state == ON) || (state == IDLE && latch);
  always_comb begin
    sh    = w << 1;
    diff  = sh[64:32] - {1'b0, dvs};
    step  = diff[32] ? sh : {diff, sh[31:1], 1'b1};
    q     = step[31:0];
    r     = step[63:32];
    fix_q = (sgn && (s1 ^ s2)) ? -q : q;
    fix_r = (sgn && s1) ? -r : r;
    mag1  = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    mag2  = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    state_nx  = state;
    cnt_nx    = cnt;
    w_nx      = w;
    dvs_nx    = dvs;
    sgn_nx    = sgn;
    s1_nx     = s1;
    s2_nx     = s2;
    result_nx = result_o;
    ready_nx  = ready_o;
    case (state)
      IDLE: if (latch) begin
        sgn_nx   = signed_div_i;
        s1_nx    = signed_div_i && opdata1_i[31];
        s2_nx    = signed_div_i && opdata2_i[31];
        dvs_nx   = mag2;
        w_nx     = {33'b0, mag1};
        cnt_nx   = 6'd0;
        state_nx = (opdata2_i == 32'b0) ? DIVZERO : ON;
      end
      DIVZERO: begin
        state_nx  = END;
        result_nx = 64'b0;
        ready_nx  = 1'b1;
      end
      ON: begin
        w_nx   = step;
        cnt_nx = cnt + 6'd1;
        if (cnt == 6'd31) begin
          state_nx  = END;
          result_nx = {fix_r, fix_q};
          ready_nx  = 1'b1;
        end
      end
      END: if (!start_i) begin
        state_nx  = IDLE;
        result_nx = 64'b0;
        ready_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
    if (annul_x && state != IDLE) begin
      state_nx  = IDLE;
      result_nx = 64'b0;
      ready_nx  = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      w        <= 65'b0;
      dvs      <= 32'b0;
      sgn      <= 1'b0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      result_o <= 64'b0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      w        <= w_nx;
      dvs      <= dvs_nx;
      sgn      <= sgn_nx;
      s1       <= s1_nx;
      s2       <= s2_nx;
      result_o <= result_nx;
      ready_o  <= ready_nx;
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors for div_seq with hand-computed results and latencies.
module tb_div_seq;
  logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, annul_i = 1'b0, signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o, busy_o;
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;
  div_seq dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
    .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n = 0, bc = 0;
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    #1;
    bc += int'(busy_o);
    while (!ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (!ready_o) bc += int'(busy_o);
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " busy cycles"}, 64'(bc), 64'(lat));
    chk({tag, " result"}, result_o, exp);
    chk({tag, " busy in end"}, 64'(busy_o), 64'd0);
    opdata1_i = 32'h1234_5678; opdata2_i = 32'h3; signed_div_i = ~s;
    repeat (2) begin @(posedge clk); #1; end
    chk({tag, " hold"}, {ready_o, result_o}, {1'b1, exp});
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, " release"}, {ready_o, result_o}, 65'b0);
  endtask
  initial begin
    int n;
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {busy_o, ready_o, result_o}, 66'b0);
    rst = 1'b0;
    run_div("u 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    run_div("s -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("s 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run_div("s -7/-2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33);
    run_div("div0", 1'b0, 32'd5, 32'd0, 64'h0, 2);
    run_div("s div0", 1'b1, 32'h80000000, 32'd0, 64'h0, 2);
    run_div("u max/1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);
    run_div("s min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    run_div("u min/max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33);
    run_div("u max/16", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33);
    // a request with annul_i high must not be taken
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    start_i = 1'b1; annul_i = 1'b1;
    #1 chk("annul idle busy", 64'(busy_o), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("annul idle no latch", {busy_o, ready_o}, 2'b00);
    start_i = 1'b0; annul_i = 1'b0;
    @(posedge clk); #1;
    // annul 10 cycles into ON
    start_i = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    annul_i = 1'b1;
`ifdef DIV_ANNUL_EN
    start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul on idle", {busy_o, ready_o, result_o}, 66'b0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= ready_o; end
    chk("annul on no ready", 64'(seen), 64'd0);
`else
    n = 11;
    @(posedge clk); #1;
    n++;
    annul_i = 1'b0;
    while (!ready_o && n < 100) begin @(posedge clk); #1; n++; end
    chk("annul ignored latency", 64'(n), 64'd33);
    chk("annul ignored result", result_o, 64'h00000002_0000000E);
    start_i = 1'b0;
    @(posedge clk); #1;
`endif
    // asynchronous reset mid-ON
    start_i = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    start_i = 1'b0;
    rst = 1'b1;
    #1 chk("rst mid on", {busy_o, ready_o, result_o}, 66'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_div("after rst 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
